mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage controller downstream of the EX_MEM pipeline register. Takes
//  MemRead/MemWrite, address and store data, and runs a req/ack handshake to a
//  multi-cycle data memory. Stalls the pipeline while an access is in flight and
//  returns load data for the MemtoReg mux. Also flags misaligned accesses and
//  memory timeouts.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width (word accesses only)
//  TIMEOUT  16  max REQ cycles without ack before abort (>=1)
// PORTS
//  clk_i        in   1       clock
//  rst_n_i      in   1       sync reset, active-low
//  MemRead_i    in   1       load request from EX_MEM
//  MemWrite_i   in   1       store request from EX_MEM
//  addr_i       in   ADDR_W  ALU result (byte address)
//  wdata_i      in   DATA_W  store data (RT)
//  stall_o      out  1       hold PC/IF_ID/ID_EX/EX_MEM this cycle
//  rdata_o      out  DATA_W  load data to MemtoReg mux
//  mem_req_o    out  1       request to memory
//  mem_we_o     out  1       1=write, 0=read
//  mem_addr_o   out  ADDR_W  word-aligned address to memory
//  mem_wdata_o  out  DATA_W  write data to memory
//  mem_ack_i    in   1       memory completion (one pulse)
//  mem_rdata_i  in   DATA_W  read data, valid with mem_ack_i
//  err_o        out  1       sticky error flag
//  err_code_o   out  2       01 misaligned, 10 timeout; first error held
// BEHAVIOUR
//  - Reset (rst_n_i=0 at edge): state IDLE. mem_req_o, mem_we_o, stall_o, err_o = 0.
//    rdata_o, mem_addr_o, mem_wdata_o, err_code_o, timeout counter = 0.
//    Applies from any state: an access in flight is dropped with no ack wait.
//  - access = MemRead_i | MemWrite_i. If both are high, the access is a write and
//    rdata_o = 0.
//  - FSM states IDLE, REQ, DONE:
//    IDLE: access with addr_i[1:0]==0 -> register addr/wdata/we, go to REQ.
//          stall_o=1 combinationally in this cycle.
//          access with addr_i[1:0]!=0 -> no request, stall_o=0, err_o<=1,
//          err_code_o<=01 if err_o was 0. Stay in IDLE.
//    REQ:  mem_req_o=1. addr/we/wdata stay stable until ack. stall_o=1.
//          The counter increments every REQ cycle.
//          mem_ack_i=1 -> rdata_o<=mem_rdata_i (read) or 0 (write), go to DONE.
//          counter==TIMEOUT-1 and no ack -> rdata_o<=0, err_o<=1,
//          err_code_o<=10 if err_o was 0, go to DONE.
//          Ack and timeout in the same cycle: ack wins.
//    DONE: mem_req_o=0, stall_o=0, rdata_o valid. The pipeline advances at the
//          end of this cycle. Go to IDLE unconditionally; no reissue.
//  - Latency: ack in cycle k of REQ (k=1 is the first) -> stall_o high for 1+k
//    cycles, then DONE. Minimum 3 cycles per access; back-to-back accesses are
//    not overlapped.
//  - mem_ack_i is ignored outside REQ. A stale ack after a timeout or reset is
//    dropped.
//  - The counter clears on entry to REQ. Width is clog2(TIMEOUT)+1.
//  - mem_addr_o = {addr[ADDR_W-1:2], 2'b00}.
//  - rdata_o holds its value until the next DONE.
//  - err_o and err_code_o clear only on reset.
// TESTING
//  1 load addr 0x10, ack with rdata 0xCAFEF00D in REQ cycle 1
//    -> stall 2 cycles, then DONE with rdata_o=0xCAFEF00D, mem_req_o high for 1 cycle.
//  2 store addr 0x20 wdata 0x1234, ack in REQ cycle 4
//    -> mem_we_o=1, addr/wdata stable for 4 cycles, stall 5 cycles, rdata_o=0.
//  3 load addr 0x13 -> no mem_req_o, stall_o=0, err_o=1, err_code_o=01.
//    A second misaligned access or a timeout leaves the code at 01.
//  4 load with no ack, TIMEOUT=16 -> mem_req_o high for exactly 16 cycles,
//    err_code_o=10, rdata_o=0. A late ack in IDLE is ignored.
//  5 rst_n_i=0 during REQ cycle 2 -> next cycle IDLE, mem_req_o=0, stall_o=0,
//    err cleared. An ack arriving next is ignored.
//  6 MemRead_i=MemWrite_i=1, aligned, two back-to-back loads
//    -> first access is a write. Second access is not requested before the DONE
//    of the first.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data memory controller: issues one word access per load/store over a
// req/ack handshake, stalls the pipeline while it is in flight, and flags errors.
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o,
    output logic [1:0]        err_code_o
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    logic [1:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic              we_q,     we_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              err_q,    err_d;
    logic [1:0]        code_q,   code_d;

    logic access_s;
    logic aligned_s;

    assign access_s  = MemRead_i | MemWrite_i;
    assign aligned_s = (addr_i[1:0] == 2'b00);

    // Next-state and datapath update for the IDLE/REQ/DONE access sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                if (access_s && aligned_s) begin
                    // A simultaneous read+write is treated as a write.
                    addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
                    wdata_d = wdata_i;
                    we_d    = MemWrite_i;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end else if (access_s) begin
                    err_d = 1'b1;
                    if (!err_q) begin
                        code_d = ERR_MISALIGN;
                    end else begin
                        code_d = code_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (mem_ack_i) begin
                    rdata_d = we_q ? '0 : mem_rdata_i;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                    if (!err_q) begin
                        code_d = ERR_TIMEOUT;
                    end else begin
                        code_d = code_q;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stall covers the issuing IDLE cycle and every REQ cycle, never DONE.
    always_comb begin
        stall_o = 1'b0;
        if (state_q == ST_REQ) begin
            stall_o = 1'b1;
        end else if (state_q == ST_IDLE) begin
            stall_o = access_s & aligned_s;
        end else begin
            stall_o = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign mem_req_o   = (state_q == ST_REQ);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign err_code_o  = code_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by random
// accesses checked against a transaction-level model of the access rules.
module tb_mem_access_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;
    logic [1:0]  err_code_o;

    int n_pass  = 0;
    int n_total = 0;

    logic        model_err;
    logic [1:0]  model_code;
    logic [31:0] model_rdata;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .stall_o     (stall_o),
        .rdata_o     (rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .err_o       (err_o),
        .err_code_o  (err_code_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'b0;
        tick();
        chk("rst_req",   32'(mem_req_o), 32'd0);
        chk("rst_stall", 32'(stall_o),   32'd0);
        chk("rst_we",    32'(mem_we_o),  32'd0);
        chk("rst_addr",  mem_addr_o,     32'd0);
        chk("rst_wdata", mem_wdata_o,    32'd0);
        chk("rst_rdata", rdata_o,        32'd0);
        chk("rst_err",   32'(err_o),     32'd0);
        chk("rst_code",  32'(err_code_o), 32'd0);
        model_err = 1'b0; model_code = 2'b00; model_rdata = 32'd0;
        rst_n_i = 1'b1;
        tick();
    endtask

    // One access at transaction level; ack_k is the REQ cycle of the ack (0 = never).
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int ack_k, input logic [31:0] ack_data);
        int          last;
        logic        aligned;
        logic [31:0] exp_rd;
        aligned = (addr % 32'd4) == 32'd0;
        MemRead_i = rd; MemWrite_i = wr; addr_i = addr; wdata_i = wdata;
        mem_ack_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;
        #1;
        chk("idle_stall", 32'(stall_o), 32'((rd | wr) & aligned));
        chk("idle_req",   32'(mem_req_o), 32'd0);
        chk("idle_rdata", rdata_o, model_rdata);
        if (!(rd | wr)) begin
            tick(); mem_ack_i = 1'b0;
            return;
        end
        if (!aligned) begin
            if (!model_err) model_code = 2'b01;
            model_err = 1'b1;
            tick();
            MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'b0;
            #1;
            chk("mis_err",   32'(err_o), 32'(model_err));
            chk("mis_code",  32'(err_code_o), 32'(model_code));
            chk("mis_req",   32'(mem_req_o), 32'd0);
            chk("mis_stall", 32'(stall_o), 32'd0);
            chk("mis_rdata", rdata_o, model_rdata);
            tick();
            return;
        end
        last = (ack_k >= 1 && ack_k <= TIMEOUT) ? ack_k : TIMEOUT;
        for (int c = 1; c <= last; c++) begin
            tick();
            mem_ack_i   = (c == ack_k);
            mem_rdata_i = (c == ack_k) ? ack_data : $urandom;
            #1;
            chk("req_req",   32'(mem_req_o), 32'd1);
            chk("req_stall", 32'(stall_o), 32'd1);
            chk("req_we",    32'(mem_we_o), 32'(wr));
            chk("req_addr",  mem_addr_o, addr);
            chk("req_wdata", mem_wdata_o, wdata);
        end
        if (ack_k == last) begin
            exp_rd = wr ? 32'd0 : ack_data;
        end else begin
            exp_rd = 32'd0;
            if (!model_err) model_code = 2'b10;
            model_err = 1'b1;
        end
        model_rdata = exp_rd;
        tick();
        mem_ack_i = 1'b0;
        #1;
        chk("done_req",   32'(mem_req_o), 32'd0);
        chk("done_stall", 32'(stall_o), 32'd0);
        chk("done_rdata", rdata_o, model_rdata);
        chk("done_err",   32'(err_o), 32'(model_err));
        chk("done_code",  32'(err_code_o), 32'(model_code));
        tick();
        MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'($urandom_range(0, 1));
        #1;
        chk("post_req",   32'(mem_req_o), 32'd0);
        chk("post_stall", 32'(stall_o), 32'd0);
        chk("post_rdata", rdata_o, model_rdata);
        tick();
        mem_ack_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rd, wr;
        logic [31:0] a;
        rst_n_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; addr_i = 32'd0;
        wdata_i = 32'd0; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
        model_err = 1'b0; model_code = 2'b00; model_rdata = 32'd0;
        tick();
        do_reset();

        do_access(1'b1, 1'b0, 32'h10, 32'h0, 1, 32'hCAFEF00D);
        do_access(1'b0, 1'b1, 32'h20, 32'h1234, 4, 32'h5555AAAA);
        do_access(1'b1, 1'b0, 32'h13, 32'h0, 1, 32'h0);
        do_access(1'b0, 1'b1, 32'h22, 32'h9, 1, 32'h0);
        do_access(1'b1, 1'b0, 32'h40, 32'h0, 0, 32'h0);

        do_reset();
        do_access(1'b1, 1'b0, 32'h48, 32'h0, 2, 32'hDEADBEEF);
        do_access(1'b1, 1'b0, 32'h44, 32'h0, 0, 32'h0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
        #1;
        chk("late_ack_req",   32'(mem_req_o), 32'd0);
        chk("late_ack_stall", 32'(stall_o), 32'd0);
        tick();
        mem_ack_i = 1'b0;
        chk("late_ack_rdata", rdata_o, 32'd0);
        chk("late_ack_req2",  32'(mem_req_o), 32'd0);
        do_access(1'b1, 1'b0, 32'h70, 32'h0, TIMEOUT, 32'h13579BDF);

        MemRead_i = 1'b1; MemWrite_i = 1'b0; addr_i = 32'h50; wdata_i = 32'h0;
        #1;
        chk("r5_stall", 32'(stall_o), 32'd1);
        tick();
        chk("r5_req1", 32'(mem_req_o), 32'd1);
        tick();
        chk("r5_req2", 32'(mem_req_o), 32'd1);
        rst_n_i = 1'b0; MemRead_i = 1'b0;
        tick();
        chk("r5_req",   32'(mem_req_o), 32'd0);
        chk("r5_stall", 32'(stall_o), 32'd0);
        chk("r5_err",   32'(err_o), 32'd0);
        chk("r5_code",  32'(err_code_o), 32'd0);
        chk("r5_rdata", rdata_o, 32'd0);
        rst_n_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
        tick();
        mem_ack_i = 1'b0;
        chk("r5_stale_req",   32'(mem_req_o), 32'd0);
        chk("r5_stale_stall", 32'(stall_o), 32'd0);
        chk("r5_stale_rdata", rdata_o, 32'd0);
        tick();
        model_err = 1'b0; model_code = 2'b00; model_rdata = 32'd0;

        do_access(1'b1, 1'b0, 32'h5C, 32'h0, 1, 32'h0BADF00D);
        do_access(1'b1, 1'b1, 32'h60, 32'hA5A5, 2, 32'h77777777);
        do_access(1'b1, 1'b1, 32'h64, 32'h5A5A, 1, 32'h66666666);

        do_reset();
        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
            do_access(rd, wr, a, $urandom, int'($urandom_range(0, 20)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
